// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the five-stage MIPS pipeline. Owns the PC, keeps at
// most one read outstanding to a variable-latency instruction memory, buffers
// returned words in a small fall-through FIFO and drives the IF/ID register.
// A redirect flushes the buffer and discards any response still in flight.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus_4
);

    localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_M1 = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    // IDLE: nothing outstanding; WAIT: one read outstanding;
    // DROP: one read outstanding whose word must be thrown away.
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_e;

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   req_pc_q,   req_pc_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
    logic                id_valid_q, id_valid_d;
    logic [DATA_W-1:0]   id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]   id_pc_q,    id_pc_d;

    logic [DATA_W-1:0]   instr_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem    [DEPTH];

    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                have_head;
    logic [DATA_W-1:0]   head_instr;
    logic [ADDR_W-1:0]   head_pc;

    // Request only when the word it returns is guaranteed a buffer slot; the
    // decision never looks at imem_ready so the handshake cannot loop.
    assign imem_req = !reset && !redirect_valid &&
                      ((state_q == ST_IDLE && count_q < DEPTH_C) ||
                       (state_q == ST_WAIT && imem_rvalid && count_q < DEPTH_M1));
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response is kept only in WAIT; in IDLE it is stale, in DROP it is flushed.
    assign push       = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign fifo_empty = (count_q == '0);

    // Fall-through head: an empty buffer hands the arriving word straight to
    // IF/ID, which is what sustains one instruction per cycle.
    assign have_head  = !fifo_empty || push;
    assign head_instr = fifo_empty ? imem_rdata : instr_mem[rd_ptr_q];
    assign head_pc    = fifo_empty ? req_pc_q   : pc_mem[rd_ptr_q];
    assign pop        = !redirect_valid && !stall && have_head;

    // Fetch FSM and PC next-state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: state_d = imem_rvalid ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) state_d = accept ? ST_WAIT : ST_IDLE;
                end
                ST_DROP: begin
                    if (imem_rvalid) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
                req_pc_d   = fetch_pc_q;
            end
        end
    end

    // Fetch-buffer pointer and occupancy next-state; a redirect empties it.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // IF/ID register next-state: redirect bubbles even under stall, stall holds.
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
        end else if (!stall) begin
            id_valid_d = have_head;
            id_instr_d = have_head ? head_instr : '0;
            if (have_head) id_pc_d = head_pc;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Buffer storage: written on every kept response.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; an entry is only read while
        // count_q says it holds a word written after reset.
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus_4 = id_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a scripted variable-latency memory, a program-order
// model of what IF/ID must show, and directed scenarios with literal values.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_4;

    // Narrow-address instance, zero-wait memory, no stall or redirect.
    logic        reset8;
    logic        stall8;
    logic        redirect_valid8;
    logic [7:0]  redirect_pc8;
    logic        imem_req8;
    logic [7:0]  imem_addr8;
    logic        imem_ready8;
    logic        imem_rvalid8;
    logic [31:0] imem_rdata8;
    logic        id_valid8;
    logic [31:0] id_instr8;
    logic [7:0]  id_pc8;
    logic [7:0]  id_pc_plus_48;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus_4(id_pc_plus_4)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'hF8), .DEPTH(2)) dut8 (
        .clk(clk), .reset(reset8), .stall(stall8),
        .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_ready(imem_ready8),
        .imem_rvalid(imem_rvalid8), .imem_rdata(imem_rdata8),
        .id_valid(id_valid8), .id_instr(id_instr8), .id_pc(id_pc8),
        .id_pc_plus_4(id_pc_plus_48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs are driven here).
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) go();
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    // ---------------- memory model for the 32-bit instance ----------------
    int          lat = 1;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          stale_inject = 0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (stale_inject) begin
            stale_inject = 0;
            imem_rvalid  = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend        = 0;
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(pend_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else if (imem_req && imem_ready) begin
            check("single_outstanding", 64'(pend), 64'h0);
            pend      = 1;
            pend_cnt  = lat;
            pend_addr = imem_addr;
        end
    end

    // ---------------- zero-wait memory for the 8-bit instance --------------
    logic       acc8 = 1'b0;
    logic [7:0] acc8_addr = '0;

    initial begin
        imem_rvalid8 = 1'b0;
        imem_rdata8  = '0;
    end

    always @(negedge clk) begin
        acc8      = !reset8 && imem_req8 && imem_ready8;
        acc8_addr = imem_addr8;
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid8 = acc8;
        imem_rdata8  = acc8 ? word_at({24'h0, acc8_addr}) : 32'h0;
    end

    // ---------------- program-order model and per-cycle compare -----------
    // IF/ID must show the fetch stream in program order: starting at the reset
    // vector, +4 per valid instruction, restarting at a redirect target. A
    // cycle after reset shows reset values, a cycle after a redirect shows a
    // bubble, a cycle after a stall shows the previous contents unchanged.
    logic [31:0] exp_pc = 32'h0;
    bit          prev_reset = 1;
    bit          prev_redirect = 0;
    bit          prev_stall = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_pc = '0;

    always @(negedge clk) begin
        if (reset) check("m_req_in_reset", 64'(imem_req), 64'h0);
        if (prev_reset) begin
            check("m_rst_valid", 64'(id_valid), 64'h0);
            check("m_rst_instr", 64'(id_instr), 64'h0);
            check("m_rst_pc", 64'(id_pc), 64'h0);
        end else if (prev_redirect) begin
            check("m_redir_valid", 64'(id_valid), 64'h0);
            check("m_redir_instr", 64'(id_instr), 64'h0);
        end else if (prev_stall) begin
            check("m_stall_valid", 64'(id_valid), 64'(prev_valid));
            check("m_stall_instr", 64'(id_instr), 64'(prev_instr));
            check("m_stall_pc", 64'(id_pc), 64'(prev_pc));
        end else if (id_valid === 1'b1) begin
            check("m_pc", 64'(id_pc), 64'(exp_pc));
            check("m_instr", 64'(id_instr), 64'(word_at(exp_pc)));
            exp_pc = exp_pc + 32'd4;
        end else begin
            check("m_bubble_instr", 64'(id_instr), 64'h0);
        end
        if (!reset) check("m_pc_plus_4", 64'(id_pc_plus_4), 64'(id_pc + 32'd4));
        if (redirect_valid) check("m_req_in_redirect", 64'(imem_req), 64'h0);

        prev_reset    = reset;
        prev_redirect = redirect_valid;
        prev_stall    = stall;
        prev_valid    = id_valid;
        prev_instr    = id_instr;
        prev_pc       = id_pc;
        if (reset) exp_pc = 32'h0;
        else if (redirect_valid) exp_pc = redirect_pc;
    end

    // ---------------- directed scenarios ----------------------------------
    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1;
        reset8 = 1'b1; stall8 = 1'b0; redirect_valid8 = 1'b0; redirect_pc8 = '0;
        imem_ready8 = 1'b1;

        go(); go();
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'h0);
        check("rst_id_valid", 64'(id_valid), 64'h0);
        check("rst_id_instr", 64'(id_instr), 64'h0);
        check("rst_id_pc", 64'(id_pc), 64'h0);
        check("rst_id_pc_plus_4", 64'(id_pc_plus_4), 64'h4);

        // Zero-wait stream from reset (cycle 0 = first cycle after reset).
        go(); reset = 1'b0; reset8 = 1'b0;
        @(negedge clk);
        check("c0_req", 64'(imem_req), 64'h1);
        check("c0_addr", 64'(imem_addr), 64'h0);
        check("a8_c0_addr", 64'(imem_addr8), 64'hF8);
        go(); go();
        @(negedge clk);
        check("c2_valid", 64'(id_valid), 64'h1);
        check("c2_pc", 64'(id_pc), 64'h0);
        check("c2_plus4", 64'(id_pc_plus_4), 64'h4);
        check("c2_instr", 64'(id_instr), 64'hA500_0000);
        check("a8_c2_pc", 64'(id_pc8), 64'hF8);
        check("a8_c2_plus4", 64'(id_pc_plus_48), 64'hFC);
        go();
        @(negedge clk);
        check("c3_pc", 64'(id_pc), 64'h4);
        check("c3_plus4", 64'(id_pc_plus_4), 64'h8);
        check("c3_instr", 64'(id_instr), 64'hA500_0004);
        check("a8_c3_pc", 64'(id_pc8), 64'hFC);
        check("a8_c3_plus4_wrap", 64'(id_pc_plus_48), 64'h00);
        go();
        @(negedge clk);
        check("c4_pc", 64'(id_pc), 64'h8);
        check("c4_plus4", 64'(id_pc_plus_4), 64'hC);
        check("c4_instr", 64'(id_instr), 64'hA500_0008);
        check("a8_c4_valid", 64'(id_valid8), 64'h1);
        check("a8_c4_pc_wrap", 64'(id_pc8), 64'h00);
        check("a8_c4_instr", 64'(id_instr8), 64'hA500_0000);

        // Stall for five cycles in steady state.
        go(); stall = 1'b1;
        @(negedge clk);
        check("st_c5_pc", 64'(id_pc), 64'hC);
        go(); go();
        @(negedge clk);
        check("st_c7_req", 64'(imem_req), 64'h0);
        check("st_c7_pc", 64'(id_pc), 64'hC);
        go(); go();
        @(negedge clk);
        check("st_c9_req", 64'(imem_req), 64'h0);
        check("st_c9_valid", 64'(id_valid), 64'h1);
        go(); stall = 1'b0;
        @(negedge clk);
        check("st_c10_pc", 64'(id_pc), 64'hC);
        go();
        @(negedge clk);
        check("st_c11_valid", 64'(id_valid), 64'h1);
        check("st_c11_pc", 64'(id_pc), 64'h10);
        go();
        @(negedge clk);
        check("st_c12_valid", 64'(id_valid), 64'h1);
        check("st_c12_pc", 64'(id_pc), 64'h14);
        go();
        @(negedge clk);
        check("st_c13_valid", 64'(id_valid), 64'h1);
        check("st_c13_pc", 64'(id_pc), 64'h18);

        // Latency-3 memory; redirect while the 0x8 read is in flight.
        go(); reset = 1'b1; lat = 3;
        go(); go(); reset = 1'b0;
        run(7); redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("rd_c7_req", 64'(imem_req), 64'h0);
        check("rd_c7_pc", 64'(id_pc), 64'h4);
        go(); redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_c8_valid", 64'(id_valid), 64'h0);
        check("rd_c8_instr", 64'(id_instr), 64'h0);
        check("rd_c8_req_drop", 64'(imem_req), 64'h0);
        go();
        @(negedge clk);
        check("rd_c9_req_drop", 64'(imem_req), 64'h0);
        go();
        @(negedge clk);
        check("rd_c10_req", 64'(imem_req), 64'h1);
        check("rd_c10_addr", 64'(imem_addr), 64'h100);
        run(3);
        @(negedge clk);
        check("rd_c13_valid", 64'(id_valid), 64'h0);
        check("rd_c13_addr", 64'(imem_addr), 64'h104);
        go();
        @(negedge clk);
        check("rd_c14_valid", 64'(id_valid), 64'h1);
        check("rd_c14_pc", 64'(id_pc), 64'h100);
        check("rd_c14_instr", 64'(id_instr), 64'hA500_0100);

        // Redirect coinciding with a response and with stall high.
        go(); go(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        check("rs_c16_rvalid", 64'(imem_rvalid), 64'h1);
        go(); stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("rs_c17_valid", 64'(id_valid), 64'h0);
        check("rs_c17_instr", 64'(id_instr), 64'h0);
        check("rs_c17_req", 64'(imem_req), 64'h1);
        check("rs_c17_addr", 64'(imem_addr), 64'h40);
        run(4);
        @(negedge clk);
        check("rs_c21_valid", 64'(id_valid), 64'h1);
        check("rs_c21_pc", 64'(id_pc), 64'h40);

        // Reset while a read is outstanding; stale response after release.
        go(); reset = 1'b1;
        go();
        go(); reset = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        check("rw_r0_req", 64'(imem_req), 64'h1);
        check("rw_r0_addr", 64'(imem_addr), 64'h0);
        stale_inject = 1;
        go(); imem_ready = 1'b1;
        @(negedge clk);
        check("rw_r1_addr", 64'(imem_addr), 64'h0);
        go();
        @(negedge clk);
        check("rw_r2_valid", 64'(id_valid), 64'h0);
        check("rw_r2_req", 64'(imem_req), 64'h0);
        run(3);
        @(negedge clk);
        check("rw_r5_valid", 64'(id_valid), 64'h1);
        check("rw_r5_pc", 64'(id_pc), 64'h0);
        check("rw_r5_instr", 64'(id_instr), 64'hA500_0000);

        run(4);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
